// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: packs four bytes per 32-bit word and writes the
// words to consecutive instruction-memory addresses, holding busy until done.
module instr_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   load_count,
  input  logic                  abort,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_WORDS = CW'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [31:0]   asm_q;
  logic [CW-1:0] remaining;
  logic          byte_ready_q;
  logic          wr_en_q;

  logic [31:0]   asm_next_c;
  logic [CW-1:0] count_c;
  logic          accept_c;

  // Abort cancels the current cycle's handshake and write immediately.
  assign byte_ready = byte_ready_q & ~abort;
  assign wr_en      = wr_en_q & ~abort;

  assign accept_c   = (state == COLLECT) && byte_valid && !abort;
  assign asm_next_c = BIG_ENDIAN ? {asm_q[23:0], byte_data} : {byte_data, asm_q[31:8]};
  assign count_c    = (load_count > MAX_WORDS) ? MAX_WORDS : load_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 2'd0;
      asm_q         <= 32'd0;
      remaining     <= '0;
      byte_ready_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr       <= BASE;
      wr_data       <= 32'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      words_written <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      wr_en_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining     <= count_c;
            wr_addr       <= BASE;
            idx           <= 2'd0;
            asm_q         <= 32'd0;
            words_written <= '0;
            if (count_c == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state        <= COLLECT;
              busy         <= 1'b1;
              byte_ready_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (abort) begin
            state        <= IDLE;
            busy         <= 1'b0;
            byte_ready_q <= 1'b0;
            aborted      <= 1'b1;
          end else if (accept_c) begin
            asm_q <= asm_next_c;
            idx   <= idx + 2'd1;
            if (idx == 2'd3) begin
              state        <= WRITE;
              wr_en_q      <= 1'b1;
              byte_ready_q <= 1'b0;
              wr_data      <= asm_next_c;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            wr_addr       <= wr_addr + ADDR_WIDTH'(1);
            words_written <= words_written + CW'(1);
            remaining     <= remaining - CW'(1);
            idx           <= 2'd0;
            if (remaining == CW'(1)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state        <= COLLECT;
              byte_ready_q <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write-side companion to the synchronous-read instruction memory.
- Takes a byte stream from a host or debug link, packs each group of four bytes into a 32-bit instruction word, and drives the memory write port at consecutive addresses.
- Lets a program be loaded at run time instead of from the init file; the core stays held off (busy) until loading completes.

Parameters:
- ADDR_WIDTH, 10, instruction memory address width (1024 words)
- BASE_ADDR, 0, first word address written on each load
- BIG_ENDIAN, 1, 1: first byte received goes to bits [31:24]; 0: first byte goes to bits [7:0]

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle load request; sampled only in IDLE
- load_count  input  ADDR_WIDTH+1  number of words to load; latched on start
- abort  input  1  cancels a load in progress
- byte_valid  input  1  byte_data is valid this cycle
- byte_data  input  8  incoming program byte
- byte_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  memory write strobe
- wr_addr  output  ADDR_WIDTH  memory write address
- wr_data  output  32  memory write data
- busy  output  1  load in progress (COLLECT or WRITE)
- done  output  1  one-cycle pulse when a load completes
- aborted  output  1  one-cycle pulse when a load is cancelled
- words_written  output  ADDR_WIDTH+1  words written in the current or last load

Behaviour:
- Reset (asynchronous, on rst high):
  - State goes to IDLE.
  - byte_ready, wr_en, busy, done and aborted go to 0.
  - wr_addr = BASE_ADDR.
  - wr_data, words_written, the byte index and the assembly register go to 0.
  - Reset during a load discards the partial word; no write is issued after rst rises.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - byte_ready = 0.
  - On start:
    - Latch count = min(load_count, 2^ADDR_WIDTH).
    - Set addr = BASE_ADDR, byte index = 0, words_written = 0.
    - If count == 0, go to DONE; otherwise go to COLLECT.
- COLLECT:
  - byte_ready = 1.
  - A byte is accepted when byte_valid && byte_ready.
  - Accepted byte is placed by byte index (0..3) according to BIG_ENDIAN.
  - On the 4th accepted byte, go to WRITE.
  - Cycles with byte_valid low are stalls; state and index are held.
- WRITE (exactly one cycle):
  - wr_en = 1, wr_addr = current addr, wr_data = assembled word; byte_ready = 0.
  - At end of cycle: addr increments modulo 2^ADDR_WIDTH (wraps from 1023 to 0), words_written increments, remaining decrements.
  - If remaining reaches 0, go to DONE; otherwise go to COLLECT with byte index 0.
- DONE:
  - done = 1 for one cycle, busy = 0; then go to IDLE.
  - wr_addr holds the last address written plus one.
- busy = 1 exactly in COLLECT and WRITE.
- Throughput: at least 5 cycles per word (4 accept cycles + 1 write cycle).
- Byte-to-memory latency: wr_en is asserted on the cycle after the 4th byte is accepted.
- Ignored inputs:
  - start outside IDLE is ignored.
  - byte_valid outside COLLECT is ignored and not consumed, since byte_ready = 0.
- abort in COLLECT or WRITE:
  - Next state is IDLE; aborted pulses for 1 cycle; done does not pulse.
  - A WRITE-cycle abort suppresses wr_en that cycle, so no write occurs.
  - A byte presented on the same cycle as abort is not accepted (byte_ready forced to 0).
  - words_written keeps the count of completed writes.
- abort in IDLE or DONE has no effect.
- If start and abort are both high in IDLE, start wins.
- wr_data and wr_addr are registered outputs; wr_data is meaningful only when wr_en = 1.

Test Plan:
1. Reset, then start with load_count=2, BIG_ENDIAN=1, bytes 12 34 56 78 9A BC DE F0 sent back-to-back:
   - Required: wr_en at addr 0 with 0x12345678, then at addr 1 with 0x9ABCDEF0, 5 cycles apart.
   - done pulses once; words_written = 2; busy is low afterwards.
2. Same stream with BIG_ENDIAN=0:
   - Required: writes of 0x78563412 and 0xF0DEBC9A.
   - Also insert random byte_valid gaps of 0-3 cycles; required: identical data and addresses.
3. BASE_ADDR=1022, load_count=3:
   - Required: writes at addresses 1022, 1023, 0.
   - load_count=2000: required: exactly 1024 writes, then done.
4. start with load_count=0:
   - Required: done pulses within 2 cycles; no wr_en; words_written = 0.
   - start held high while busy: required: no restart and count unchanged.
5. abort after 6 bytes of a 4-word load:
   - Required: exactly 1 write (word 0); aborted pulses; no done pulse; state IDLE.
   - abort on the WRITE cycle: required: wr_en stays 0 that cycle.
6. Assert rst for 1 cycle mid-COLLECT:
   - Required: all outputs drop to reset values immediately (asynchronously).
   - A subsequent load of 1 word writes at BASE_ADDR with no residue from the partial word.
